sar_frontend_model: RTL
=======================

SAR_FRONTEND_MODEL -- requirements
Module: sar_frontend_model

Interface
REQ-001 Parameter WIDTH, default 12: sample and trial-code width.
REQ-002 Parameter LATENCY, default 1, legal 1..4: comparator decision delay in clk cycles.
REQ-003 Parameter TIMEOUT, default 64: maximum HOLD cycles before abort.
REQ-004 Parameter TOL, default 1: maximum |result - sample| accepted as match.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-007 in_valid  input  1  new analog sample offered.
REQ-008 in_data  input  WIDTH  sample value (unsigned).
REQ-009 in_ready  output  1  block can accept a sample.
REQ-010 bitout  input  WIDTH  current trial/final code from the SAR logic.
REQ-011 conv_done  input  1  SAR end-of-conversion flag.
REQ-012 d  output  1  comparator decision to the SAR logic.
REQ-013 result_valid  output  1  one-cycle strobe, result fields valid.
REQ-014 result  output  WIDTH  code captured at end of conversion.
REQ-015 result_match  output  1  |result - held sample| <= TOL and no timeout.
REQ-016 result_timeout  output  1  conversion aborted by timeout.
REQ-017 conv_count  output  16  completed reports, saturating at 16'hFFFF.
REQ-018 err_count  output  16  reports with result_match=0, saturating at 16'hFFFF.

Function
REQ-019 FSM states SHALL be IDLE, HOLD, REPORT; reset state IDLE.
REQ-020 in_ready SHALL be 1 only in IDLE; in_valid&&in_ready SHALL latch in_data into held sample and go to HOLD next cycle.
REQ-021 Raw decision SHALL be (held sample >= bitout) in HOLD, 0 otherwise, delayed through exactly LATENCY registers to d.
REQ-022 On acceptance the decision pipeline SHALL be flushed to 0 and the timeout counter cleared.
REQ-023 conv_done SHALL be edge-detected with a registered previous value; only a 0->1 transition observed in HOLD ends the conversion; conv_done already high on entry is ignored until it falls.
REQ-024 On that rising edge, bitout in the same cycle SHALL be captured into result and the FSM SHALL go to REPORT.
REQ-025 In HOLD the timeout counter SHALL increment each cycle; at TIMEOUT-1 without a conv_done rise, FSM SHALL go to REPORT with result_timeout=1, result=bitout, result_match=0.
REQ-026 Simultaneous conv_done rise and timeout SHALL be treated as a normal completion (timeout=0).
REQ-027 Match SHALL use unsigned absolute difference computed at WIDTH+1 bits, no wrap-around.
REQ-028 REPORT SHALL last exactly one cycle with result_valid=1, then return to IDLE; result, result_match, result_timeout SHALL hold until the next REPORT.
REQ-029 conv_count SHALL increment in every REPORT cycle; err_count SHALL increment in REPORT when result_match=0; both saturate, never wrap.
REQ-030 in_valid outside IDLE SHALL be ignored with no effect on held sample.

Reset
REQ-031 While reset is low: state IDLE, in_ready=1 after release, d=0, pipeline=0, result_valid=0, result=0, result_match=0, result_timeout=0, conv_count=0, err_count=0, held sample=0.
REQ-032 Reset asserted mid-HOLD or REPORT SHALL abort without a report and without counter updates.

Verification
REQ-033 Sample 0x800 with behavioural 12-bit SAR closing the loop -> result=0x800, result_match=1, result_valid one cycle, conv_count=1.
REQ-034 Samples 0xFFF then 0x000 -> d constantly 1 then constantly 0 (after LATENCY), results 0xFFF and 0x000, both match, conv_count=2, err_count=0.
REQ-035 Sample 0x120, bitout forced 0x123 at conv_done rise -> result=0x123, result_match=0, err_count=1; with bitout 0x121 -> result_match=1.
REQ-036 Sample accepted, conv_done held low -> REPORT after 64 HOLD cycles, result_timeout=1, result_match=0, err_count increments.
REQ-037 conv_done high at acceptance, fall, then rise after 10 cycles -> only the later rise completes; LATENCY=3 build shows d lagging raw decision by exactly 3 cycles.
REQ-038 Reset pulsed low mid-HOLD -> all outputs at reset values, no result_valid, counters 0, in_ready=1 one cycle after release.

Source files
------------

// File: rtl/sar_frontend_model_if.sv
// Sample handshake, SAR comparator loop and result reporting bus for sar_frontend_model.
interface sar_frontend_model_if #(
    parameter int unsigned WIDTH = 12
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic [WIDTH-1:0] bitout;
    logic             conv_done;
    logic             d;
    logic             result_valid;
    logic [WIDTH-1:0] result;
    logic             result_match;
    logic             result_timeout;
    logic [15:0]      conv_count;
    logic [15:0]      err_count;

    modport master (
        output in_valid, in_data, bitout, conv_done,
        input  in_ready, d, result_valid, result, result_match, result_timeout,
               conv_count, err_count
    );

    modport slave (
        input  in_valid, in_data, bitout, conv_done,
        output in_ready, d, result_valid, result, result_match, result_timeout,
               conv_count, err_count
    );
endinterface

// File: rtl/sar_frontend_model.sv
// Analog front-end stand-in for a SAR ADC: holds a sample, answers comparator trials
// with a delayed decision, and reports/scores the final code against the held sample.
module sar_frontend_model #(
    parameter int unsigned WIDTH   = 12,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned TOL     = 1
) (
    input logic                 clk,
    input logic                 reset,
    sar_frontend_model_if.slave bus
);
    localparam int unsigned TW = $clog2(TIMEOUT) + 1;
    localparam int unsigned W1 = WIDTH + 1;

    typedef enum logic [1:0] {IDLE, HOLD, REPORT} state_t;

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   held;
    logic [LATENCY-1:0] pipe;
    logic [TW-1:0]      tcnt;
    logic               conv_prev;
    logic               ready_q;
    logic               valid_q;
    logic [WIDTH-1:0]   result_q;
    logic               match_q;
    logic               timeout_q;
    logic [15:0]        conv_q;
    logic [15:0]        err_q;

    logic               accept_c;
    logic               done_c;
    logic               tmo_c;
    logic               raw_c;
    logic               rise_c;
    logic [W1-1:0]      diff_c;
    logic               match_c;

    // Comparator model and tolerance check; difference kept one bit wider so it never wraps.
    always_comb begin
        raw_c  = (state == HOLD) && (held >= bus.bitout);
        rise_c = bus.conv_done && !conv_prev;
        if ({1'b0, held} >= {1'b0, bus.bitout}) begin
            diff_c = {1'b0, held} - {1'b0, bus.bitout};
        end else begin
            diff_c = {1'b0, bus.bitout} - {1'b0, held};
        end
        match_c = (diff_c <= W1'(TOL));
    end

    // Next-state logic; a conv_done rise wins over a coincident timeout.
    always_comb begin
        next_state = state;
        accept_c   = 1'b0;
        done_c     = 1'b0;
        tmo_c      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    accept_c   = 1'b1;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (rise_c) begin
                    done_c     = 1'b1;
                    next_state = REPORT;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    tmo_c      = 1'b1;
                    next_state = REPORT;
                end
            end
            REPORT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ready_q   <= 1'b1;
            held      <= '0;
            pipe      <= '0;
            tcnt      <= '0;
            conv_prev <= 1'b0;
            valid_q   <= 1'b0;
            result_q  <= '0;
            match_q   <= 1'b0;
            timeout_q <= 1'b0;
            conv_q    <= '0;
            err_q     <= '0;
        end else begin
            state     <= next_state;
            ready_q   <= (next_state == IDLE);
            conv_prev <= bus.conv_done;
            valid_q   <= done_c | tmo_c;
            if (accept_c) begin
                held <= bus.in_data;
                pipe <= '0;
                tcnt <= '0;
            end else begin
                pipe <= LATENCY'({pipe, raw_c});
                if (state == HOLD) begin
                    tcnt <= tcnt + TW'(1);
                end
            end
            if (done_c || tmo_c) begin
                result_q  <= bus.bitout;
                match_q   <= done_c && match_c;
                timeout_q <= tmo_c;
            end
            // Counters advance as the one-cycle report is retired.
            if (state == REPORT) begin
                if (conv_q != 16'hFFFF) begin
                    conv_q <= conv_q + 16'd1;
                end
                if (!match_q && (err_q != 16'hFFFF)) begin
                    err_q <= err_q + 16'd1;
                end
            end
        end
    end

    assign bus.in_ready       = ready_q;
    assign bus.d              = pipe[LATENCY-1];
    assign bus.result_valid   = valid_q;
    assign bus.result         = result_q;
    assign bus.result_match   = match_q;
    assign bus.result_timeout = timeout_q;
    assign bus.conv_count     = conv_q;
    assign bus.err_count      = err_q;
endmodule
